cdb_tx: RTL and testbench
=========================

Name: cdb_tx

Overview:
- Per-functional-unit transmit stage for the common data bus (CDB).
- Buffers up to two completions per cycle from one FU (ALU-simple, multiplier or memory) in an in-order circular queue.
- Presents the oldest one or two completions on two CDB request lanes.
- Retires entries when the CDB arbiter grants them; back-pressures the FU with a stall when space is short.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2.
- PR_IDX_W, 6, physical register tag width.
- AR_IDX_W, 5, architectural register index width.
- DATA_W, 64, result value width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous squash (branch mispredict / exception recovery).
- fu_valid0 / fu_valid1  input  1  FU completion lane k valid; lane 0 older.
- fu_pr_idx0 / fu_pr_idx1  input  PR_IDX_W  destination physical tag, lane k.
- fu_ar_idx0 / fu_ar_idx1  input  AR_IDX_W  destination architectural index, lane k.
- fu_value0 / fu_value1  input  DATA_W  result, lane k.
- fu_exception0 / fu_exception1  input  1  exception flag, lane k.
- fu_stall  output  1  FU must not present completions this cycle.
- cdb_req0 / cdb_req1  output  1  request on CDB lane k; lane 0 is the oldest entry.
- cdb_pr_idx0 / cdb_pr_idx1  output  PR_IDX_W  tag on lane k.
- cdb_ar_idx0 / cdb_ar_idx1  output  AR_IDX_W  arch index on lane k.
- cdb_value0 / cdb_value1  output  DATA_W  value on lane k.
- cdb_exception0 / cdb_exception1  output  1  exception on lane k.
- cdb_grant0 / cdb_grant1  input  1  arbiter accepts lane k this cycle.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, active-high):
  - head=tail=count=0; storage payload cleared.
  - cdb_req0/1=0, all cdb_* payload=0, fu_stall=0.
- Storage and latency:
  - Storage is registered; cdb_* outputs are combinational from head and head+1 entries.
  - An accepted completion is first visible on cdb_req0 the cycle after push, so push-to-request latency is 1.
  - No same-cycle bypass.
- Request outputs:
  - cdb_req0 = (count>=1); cdb_req1 = (count>=2).
  - Payload on a lane with req low is driven 0, so the CDB can OR lanes.
- Stall: fu_stall = (DEPTH - count) < 2, from the registered count. This is conservative: it ignores same-cycle pops.
- Push rules:
  - When !fu_stall, each asserted fu_valid lane is written at tail in lane order.
  - fu_valid1 alone is stored as a single entry.
  - tail advances by the number of pushes.
  - Valids presented while fu_stall=1 are dropped; this is a protocol violation and the bench asserts on it.
- Pop rules:
  - cdb_grant0 && cdb_req0 pops head.
  - cdb_grant1 pops head+1 only if cdb_grant0 && cdb_req1 in the same cycle.
  - cdb_grant1 without cdb_grant0, or a grant with req low, is ignored (no pop).
- Simultaneous push and pop are legal: count_next = count + pushes - pops.
- Wrap-around: head/tail are modulo DEPTH (natural pointer overflow). count distinguishes full from empty.
- Flush:
  - Highest priority: head=tail=count=0 next cycle.
  - Same-cycle pushes and grants are discarded; cdb_req0/1=0 the following cycle.
- Reset mid-operation drops all entries immediately, asynchronously.
- Entries are never reordered; exception bits and tags pass through unmodified.

Decomposition:
- Shared defs header (sys_defs):
  - PR_IDX_W, AR_IDX_W, DATA_W.
  - CDB entry field layout {pr_idx, ar_idx, value, exception} and its packed width CDB_ENTRY_W.
  - Shared with the cdb, rs, rob and map_table blocks.
- One natural sub-module, cdb_tx_cq: 2-write/2-read circular buffer holding packed entries, with pointers and count.
- cdb_tx wraps cdb_tx_cq with the stall, grant and flush logic.

Test Plan:
- Reset, then single push fu_valid0=1, pr=6'h0A, ar=5'd3, value=64'h1234 -> next cycle cdb_req0=1 with the same fields and cdb_req1=0; grant0 -> count 1->0, req0=0 the next cycle.
- Dual push lanes pr=1,2 for 2 cycles (DEPTH=4) with no grants -> count=4, fu_stall=1. Grant0+grant1 -> pr=1,2 retire and lane0 shows pr=3, lane1 pr=4. Then count=2, fu_stall=0.
- grant1=1, grant0=0 with count=2 -> no pop, count stays 2. Then grant0 only -> lane0 becomes old lane1's pr.
- Wrap: 7 single push/pop pairs with tags 0..6, one per cycle -> the CDB sees tags in order 0..6 and count never exceeds 1.
- Flush with count=3, plus same-cycle fu_valid0 and grant0 -> count=0 and req0=req1=0 next cycle; the push is lost.
- Assert reset asynchronously mid-cycle with count=2 -> cdb_req0/1 and count drop to 0 before the next clock edge; fu_stall=0.

Source files
------------

// File: rtl/cdb_tx_pkg.sv
// Shared CDB definitions: register-index widths, result width and the packed
// CDB entry layout used by the cdb, rs, rob and map_table blocks.
package cdb_tx_pkg;

    localparam int PR_IDX_W = 6;
    localparam int AR_IDX_W = 5;
    localparam int DATA_W   = 64;

    typedef struct packed {
        logic [PR_IDX_W-1:0] pr_idx;
        logic [AR_IDX_W-1:0] ar_idx;
        logic [DATA_W-1:0]   value;
        logic                exception;
    } cdb_entry_t;

    localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

    function automatic cdb_entry_t pack_entry(
        input logic [PR_IDX_W-1:0] pr_idx,
        input logic [AR_IDX_W-1:0] ar_idx,
        input logic [DATA_W-1:0]   value,
        input logic                exception
    );
        cdb_entry_t e;
        e.pr_idx    = pr_idx;
        e.ar_idx    = ar_idx;
        e.value     = value;
        e.exception = exception;
        return e;
    endfunction

endpackage

// File: rtl/cdb_tx_cq.sv
// Two-write / two-read in-order circular queue of CDB entries.
// Writes land at tail/tail+1, reads come from head/head+1; count separates full from empty.
module cdb_tx_cq
    import cdb_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             push_cnt,
    input  cdb_entry_t             wr_data0,
    input  cdb_entry_t             wr_data1,
    input  logic [1:0]             pop_cnt,
    output cdb_entry_t             rd_data0,
    output cdb_entry_t             rd_data1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    assign head_p1  = head + PTR_W'(1);
    assign tail_p1  = tail + PTR_W'(1);
    assign rd_data0 = mem[head];
    assign rd_data1 = mem[head_p1];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem[tail] <= wr_data0;
            end
            if (push_cnt == 2'd2) begin
                mem[tail_p1] <= wr_data1;
            end
            tail  <= tail + PTR_W'(push_cnt);
            head  <= head + PTR_W'(pop_cnt);
            count <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        end
    end

endmodule

// File: rtl/cdb_tx.sv
// Per-FU CDB transmit stage: queues FU completions, offers the oldest two on the
// CDB request lanes, retires them on grant and stalls the FU when space is short.
module cdb_tx
    import cdb_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   fu_valid0,
    input  logic                   fu_valid1,
    input  logic [PR_IDX_W-1:0]    fu_pr_idx0,
    input  logic [PR_IDX_W-1:0]    fu_pr_idx1,
    input  logic [AR_IDX_W-1:0]    fu_ar_idx0,
    input  logic [AR_IDX_W-1:0]    fu_ar_idx1,
    input  logic [DATA_W-1:0]      fu_value0,
    input  logic [DATA_W-1:0]      fu_value1,
    input  logic                   fu_exception0,
    input  logic                   fu_exception1,
    output logic                   fu_stall,
    output logic                   cdb_req0,
    output logic                   cdb_req1,
    output logic [PR_IDX_W-1:0]    cdb_pr_idx0,
    output logic [PR_IDX_W-1:0]    cdb_pr_idx1,
    output logic [AR_IDX_W-1:0]    cdb_ar_idx0,
    output logic [AR_IDX_W-1:0]    cdb_ar_idx1,
    output logic [DATA_W-1:0]      cdb_value0,
    output logic [DATA_W-1:0]      cdb_value1,
    output logic                   cdb_exception0,
    output logic                   cdb_exception1,
    input  logic                   cdb_grant0,
    input  logic                   cdb_grant1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    cdb_entry_t in0;
    cdb_entry_t in1;
    cdb_entry_t wr_data0;
    cdb_entry_t rd_data0;
    cdb_entry_t rd_data1;
    cdb_entry_t lane0;
    cdb_entry_t lane1;
    logic [1:0] push_cnt;
    logic [1:0] pop_cnt;
    logic       pop0;
    logic       pop1;

    assign in0 = pack_entry(fu_pr_idx0, fu_ar_idx0, fu_value0, fu_exception0);
    assign in1 = pack_entry(fu_pr_idx1, fu_ar_idx1, fu_value1, fu_exception1);

    // A lone lane-1 completion still goes into the tail slot.
    assign wr_data0 = fu_valid0 ? in0 : in1;

    // Stall looks only at the registered count, so it never waits on this cycle's grants.
    assign fu_stall = (count > CNT_W'(DEPTH - 2));
    assign push_cnt = fu_stall ? 2'd0 : ({1'b0, fu_valid0} + {1'b0, fu_valid1});

    assign cdb_req0 = (count != '0);
    assign cdb_req1 = (count >= CNT_W'(2));

    assign pop0    = cdb_grant0 && cdb_req0;
    assign pop1    = pop0 && cdb_grant1 && cdb_req1;
    assign pop_cnt = {1'b0, pop0} + {1'b0, pop1};

    cdb_tx_cq #(.DEPTH(DEPTH)) u_cq (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push_cnt (push_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (in1),
        .pop_cnt  (pop_cnt),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .count    (count)
    );

    // Idle lanes drive zero so the CDB can OR lanes from several FUs.
    assign lane0 = cdb_req0 ? rd_data0 : '0;
    assign lane1 = cdb_req1 ? rd_data1 : '0;

    assign cdb_pr_idx0    = lane0.pr_idx;
    assign cdb_ar_idx0    = lane0.ar_idx;
    assign cdb_value0     = lane0.value;
    assign cdb_exception0 = lane0.exception;
    assign cdb_pr_idx1    = lane1.pr_idx;
    assign cdb_ar_idx1    = lane1.ar_idx;
    assign cdb_value1     = lane1.value;
    assign cdb_exception1 = lane1.exception;

endmodule

// File: tb/tb_cdb_tx.sv
// Directed bench for cdb_tx (DEPTH=4): a vector table for the queue/grant/flush
// behaviour plus hand-written sequences for the first push and async reset.
module tb_cdb_tx;
    import cdb_tx_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic                fu_valid0, fu_valid1;
    logic [PR_IDX_W-1:0] fu_pr_idx0, fu_pr_idx1;
    logic [AR_IDX_W-1:0] fu_ar_idx0, fu_ar_idx1;
    logic [DATA_W-1:0]   fu_value0, fu_value1;
    logic                fu_exception0, fu_exception1;
    logic                fu_stall;
    logic                cdb_req0, cdb_req1;
    logic [PR_IDX_W-1:0] cdb_pr_idx0, cdb_pr_idx1;
    logic [AR_IDX_W-1:0] cdb_ar_idx0, cdb_ar_idx1;
    logic [DATA_W-1:0]   cdb_value0, cdb_value1;
    logic                cdb_exception0, cdb_exception1;
    logic                cdb_grant0, cdb_grant1;
    logic [2:0]          count;

    int vectors = 0;
    int miscompares = 0;

    cdb_tx #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_valid0(fu_valid0), .fu_valid1(fu_valid1),
        .fu_pr_idx0(fu_pr_idx0), .fu_pr_idx1(fu_pr_idx1),
        .fu_ar_idx0(fu_ar_idx0), .fu_ar_idx1(fu_ar_idx1),
        .fu_value0(fu_value0), .fu_value1(fu_value1),
        .fu_exception0(fu_exception0), .fu_exception1(fu_exception1),
        .fu_stall(fu_stall),
        .cdb_req0(cdb_req0), .cdb_req1(cdb_req1),
        .cdb_pr_idx0(cdb_pr_idx0), .cdb_pr_idx1(cdb_pr_idx1),
        .cdb_ar_idx0(cdb_ar_idx0), .cdb_ar_idx1(cdb_ar_idx1),
        .cdb_value0(cdb_value0), .cdb_value1(cdb_value1),
        .cdb_exception0(cdb_exception0), .cdb_exception1(cdb_exception1),
        .cdb_grant0(cdb_grant0), .cdb_grant1(cdb_grant1),
        .count(count)
    );

    always #5 clock = ~clock;

    // Payload fields are derived from the tag so each lane's packing is checked.
    function automatic logic [AR_IDX_W-1:0] ar_of(input logic [PR_IDX_W-1:0] pr);
        return pr[AR_IDX_W-1:0] ^ 5'h15;
    endfunction
    function automatic logic [DATA_W-1:0] val_of(input logic [PR_IDX_W-1:0] pr);
        return 64'h0123_4567_89AB_CDEF + {58'd0, pr};
    endfunction
    function automatic logic exc_of(input logic [PR_IDX_W-1:0] pr);
        return pr[0];
    endfunction

    typedef struct {
        logic       v0, v1;
        logic [5:0] p0, p1;
        logic       g0, g1, fl;
        logic       r0, r1;
        logic [5:0] e0, e1;
        logic [2:0] cnt;
        logic       stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v0, v1, input logic [5:0] p0, p1,
                                input logic g0, g1, fl, r0, r1,
                                input logic [5:0] e0, e1, input logic [2:0] cnt,
                                input logic stall);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.p0 = p0; v.p1 = p1;
        v.g0 = g0; v.g1 = g1; v.fl = fl;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
        v.cnt = cnt; v.stall = stall;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic r0, r1,
                               input logic [5:0] e0, e1, input logic [2:0] cnt,
                               input logic stall);
        vectors++;
        cmp({tag, " req0"},  64'(cdb_req0), 64'(r0));
        cmp({tag, " req1"},  64'(cdb_req1), 64'(r1));
        cmp({tag, " count"}, 64'(count), 64'(cnt));
        cmp({tag, " stall"}, 64'(fu_stall), 64'(stall));
        cmp({tag, " pr0"},   64'(cdb_pr_idx0), r0 ? 64'(e0) : 64'd0);
        cmp({tag, " ar0"},   64'(cdb_ar_idx0), r0 ? 64'(ar_of(e0)) : 64'd0);
        cmp({tag, " val0"},  cdb_value0, r0 ? val_of(e0) : 64'd0);
        cmp({tag, " exc0"},  64'(cdb_exception0), r0 ? 64'(exc_of(e0)) : 64'd0);
        cmp({tag, " pr1"},   64'(cdb_pr_idx1), r1 ? 64'(e1) : 64'd0);
        cmp({tag, " ar1"},   64'(cdb_ar_idx1), r1 ? 64'(ar_of(e1)) : 64'd0);
        cmp({tag, " val1"},  cdb_value1, r1 ? val_of(e1) : 64'd0);
        cmp({tag, " exc1"},  64'(cdb_exception1), r1 ? 64'(exc_of(e1)) : 64'd0);
    endtask

    task automatic drive(input logic v0, v1, input logic [5:0] p0, p1,
                         input logic g0, g1, fl);
        fu_valid0 = v0; fu_valid1 = v1;
        fu_pr_idx0 = p0; fu_ar_idx0 = ar_of(p0); fu_value0 = val_of(p0); fu_exception0 = exc_of(p0);
        fu_pr_idx1 = p1; fu_ar_idx1 = ar_of(p1); fu_value1 = val_of(p1); fu_exception1 = exc_of(p1);
        cdb_grant0 = g0; cdb_grant1 = g1; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Valids under stall are a protocol violation unless the cycle is being flushed anyway.
    task automatic protocol_check();
        if (fu_stall && (fu_valid0 || fu_valid1) && !flush) begin
            miscompares++;
            $display("FAIL protocol: fu_valid asserted while fu_stall=1");
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Stalled valids are permitted only in the flush row.
        vecs.push_back(mk(1,1, 6'd1, 6'd2, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        vecs.push_back(mk(1,1, 6'd3, 6'd4, 0,0,0, 1,1, 6'd1, 6'd2, 3'd2, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 0,0,0, 1,1, 6'd1, 6'd2, 3'd4, 1));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 1,1,0, 1,1, 6'd1, 6'd2, 3'd4, 1));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 0,1,0, 1,1, 6'd3, 6'd4, 3'd2, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 1,0,0, 1,1, 6'd3, 6'd4, 3'd2, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 1,0,0, 1,0, 6'd4, 6'd0, 3'd1, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        // wrap-around: push tag k while granting tag k-1
        vecs.push_back(mk(1,0, 6'd0, 6'd0, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        for (int k = 1; k <= 6; k++)
            vecs.push_back(mk(1,0, 6'(k), 6'd0, 1,0,0, 1,0, 6'(k-1), 6'd0, 3'd1, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 1,0,0, 1,0, 6'd6, 6'd0, 3'd1, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        // lane1-only push is stored as a single entry
        vecs.push_back(mk(0,1, 6'd0, 6'd9, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 1,1,0, 1,0, 6'd9, 6'd0, 3'd1, 0));
        // flush with count=3 plus same-cycle push and grant
        vecs.push_back(mk(1,1, 6'd10, 6'd11, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        vecs.push_back(mk(1,0, 6'd12, 6'd0, 0,0,0, 1,1, 6'd10, 6'd11, 3'd2, 0));
        vecs.push_back(mk(1,0, 6'd13, 6'd0, 1,0,1, 1,1, 6'd10, 6'd11, 3'd3, 1));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));
        vecs.push_back(mk(0,0, 6'd0, 6'd0, 0,0,0, 0,0, 6'd0, 6'd0, 3'd0, 0));

        repeat (2) @(negedge clock);
        #1 check_state("reset", 0, 0, 6'd0, 6'd0, 3'd0, 0);
        @(negedge clock);
        reset = 1'b0;

        // First push with literal payload: visible one cycle later, then retired by grant0.
        fu_valid0 = 1'b1; fu_pr_idx0 = 6'h0A; fu_ar_idx0 = 5'd3;
        fu_value0 = 64'h1234; fu_exception0 = 1'b0;
        #1 protocol_check();
        @(negedge clock);
        idle();
        #1 vectors++;
        cmp("push1 req0", 64'(cdb_req0), 64'd1);
        cmp("push1 req1", 64'(cdb_req1), 64'd0);
        cmp("push1 pr0", 64'(cdb_pr_idx0), 64'h0A);
        cmp("push1 ar0", 64'(cdb_ar_idx0), 64'd3);
        cmp("push1 val0", cdb_value0, 64'h1234);
        cmp("push1 exc0", 64'(cdb_exception0), 64'd0);
        cmp("push1 count", 64'(count), 64'd1);
        cdb_grant0 = 1'b1;
        @(negedge clock);
        idle();
        #1 check_state("pop1", 0, 0, 6'd0, 6'd0, 3'd0, 0);

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].v0, vecs[i].v1, vecs[i].p0, vecs[i].p1,
                  vecs[i].g0, vecs[i].g1, vecs[i].fl);
            #1 check_state($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1,
                           vecs[i].e0, vecs[i].e1, vecs[i].cnt, vecs[i].stall);
            protocol_check();
        end

        // Async reset in mid-cycle with two entries queued.
        @(negedge clock);
        drive(1'b1, 1'b1, 6'd20, 6'd21, 1'b0, 1'b0, 1'b0);
        #1 protocol_check();
        @(negedge clock);
        idle();
        #1 check_state("pre_rst", 1, 1, 6'd20, 6'd21, 3'd2, 0);
        #1 reset = 1'b1;
        #1 check_state("async_rst", 0, 0, 6'd0, 6'd0, 3'd0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1 check_state("post_rst", 0, 0, 6'd0, 6'd0, 3'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
